// File: rtl/fpu_dispatch_pkg.sv
// Shared encodings for the FPU issue path: op codes, execution unit indices and dispatcher states.
// Optional abort of a stalled unit is enabled by defining FPU_DISPATCH_TIMEOUT_EN.
package fpu_dispatch_pkg;

    localparam logic [3:0] OP_ADD      = 4'd0;
    localparam logic [3:0] OP_SUB      = 4'd1;
    localparam logic [3:0] OP_MUL      = 4'd2;
    localparam logic [3:0] OP_DIV      = 4'd3;
    localparam logic [3:0] OP_FEQ      = 4'd4;
    localparam logic [3:0] OP_FLT      = 4'd5;
    localparam logic [3:0] OP_FLE      = 4'd6;
    localparam logic [3:0] OP_CVT_W_S  = 4'd7;
    localparam logic [3:0] OP_CVT_WU_S = 4'd8;
    localparam logic [3:0] OP_CVT_S_W  = 4'd9;
    localparam logic [3:0] OP_CVT_S_WU = 4'd10;
    localparam logic [3:0] OP_SGNJ     = 4'd11;
    localparam logic [3:0] OP_SGNJN    = 4'd12;
    localparam logic [3:0] OP_SGNJX    = 4'd13;

    localparam logic [2:0] U_ADDSUB = 3'd0;
    localparam logic [2:0] U_MUL    = 3'd1;
    localparam logic [2:0] U_DIV    = 3'd2;
    localparam logic [2:0] U_CMP    = 3'd3;
    localparam logic [2:0] U_CVT    = 3'd4;
    localparam logic [2:0] U_SGNJ   = 3'd5;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

endpackage

// File: rtl/fpu_op_decode.sv
// Maps an FPU_Control op code onto the execution unit that implements it.
// Codes 14 and 15 have no unit and are flagged illegal.
module fpu_op_decode
    import fpu_dispatch_pkg::*;
(
    input  logic [3:0] fpu_control,
    output logic [2:0] unit,
    output logic       illegal
);

    always_comb begin
        unit    = U_ADDSUB;
        illegal = 1'b0;
        case (fpu_control)
            OP_ADD, OP_SUB:                                     unit = U_ADDSUB;
            OP_MUL:                                             unit = U_MUL;
            OP_DIV:                                             unit = U_DIV;
            OP_FEQ, OP_FLT, OP_FLE:                             unit = U_CMP;
            OP_CVT_W_S, OP_CVT_WU_S, OP_CVT_S_W, OP_CVT_S_WU:   unit = U_CVT;
            OP_SGNJ, OP_SGNJN, OP_SGNJX:                        unit = U_SGNJ;
            default:                                            illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/fpu_op_dispatch.sv
// Issues one FP op at a time to its execution unit, waits for done and holds the result for writeback.
// Define FPU_DISPATCH_TIMEOUT_EN to abort a WAIT that exceeds TIMEOUT_CYC cycles.
module fpu_op_dispatch
    import fpu_dispatch_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int NUM_UNITS   = 6,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        op_valid,
    output logic                        op_ready,
    input  logic [3:0]                  FPU_Control,
    input  logic [DATA_W-1:0]           rs1_data,
    input  logic [DATA_W-1:0]           rs2_data,
    output logic [NUM_UNITS-1:0]        unit_start,
    output logic [DATA_W-1:0]           unit_a,
    output logic [DATA_W-1:0]           unit_b,
    output logic [3:0]                  unit_ctrl,
    input  logic [NUM_UNITS-1:0]        unit_done,
    input  logic [NUM_UNITS*DATA_W-1:0] unit_result,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [DATA_W-1:0]           res_data,
    output logic                        res_illegal,
    output logic                        res_timeout
);

    state_t            state;
    logic [2:0]        sel;
    logic [2:0]        dec_unit;
    logic              dec_illegal;
    logic              sel_done;
    logic [DATA_W-1:0] sel_result;
    logic              timeout_hit;

    fpu_op_decode u_decode (
        .fpu_control (FPU_Control),
        .unit        (dec_unit),
        .illegal     (dec_illegal)
    );

    // Only the selected unit is listened to; done from any other unit is ignored.
    assign sel_done   = unit_done[sel];
    assign sel_result = unit_result[sel*DATA_W +: DATA_W];

`ifdef FPU_DISPATCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wait_cnt;

    assign timeout_hit = (state == WAIT) && !sel_done && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt    <= '0;
            res_timeout <= 1'b0;
        end else begin
            if (state == IDLE && op_valid)
                wait_cnt <= '0;
            else if (state == WAIT)
                wait_cnt <= wait_cnt + 1'b1;
            if (timeout_hit)
                res_timeout <= 1'b1;
            else if (state == HOLD && res_ready)
                res_timeout <= 1'b0;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign res_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sel         <= '0;
            op_ready    <= 1'b1;
            unit_start  <= '0;
            unit_a      <= '0;
            unit_b      <= '0;
            unit_ctrl   <= '0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_illegal <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        op_ready  <= 1'b0;
                        unit_a    <= rs1_data;
                        unit_b    <= rs2_data;
                        unit_ctrl <= FPU_Control;
                        sel       <= dec_unit;
                        if (dec_illegal) begin
                            res_illegal <= 1'b1;
                            res_data    <= '0;
                            res_valid   <= 1'b1;
                            state       <= HOLD;
                        end else begin
                            unit_start <= NUM_UNITS'(1) << dec_unit;
                            state      <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    unit_start <= '0;
                    if (sel_done) begin
                        res_data  <= sel_result;
                        res_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (sel_done) begin
                        res_data  <= sel_result;
                        res_valid <= 1'b1;
                        state     <= HOLD;
                    end else if (timeout_hit) begin
                        res_data  <= '0;
                        res_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    // Returning to IDLE takes the whole cycle, so no op is accepted on the release edge.
                    if (res_ready) begin
                        res_valid   <= 1'b0;
                        res_illegal <= 1'b0;
                        op_ready    <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_op_dispatch.sv
// Randomized and directed bench for fpu_op_dispatch with a behavioural op-to-unit reference model.
// Covers the FPU_DISPATCH_TIMEOUT_EN abort path when that macro is defined.
module tb_fpu_op_dispatch;

    localparam int DATA_W      = 32;
    localparam int NUM_UNITS   = 6;
    localparam int TIMEOUT_CYC = 64;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic                        op_valid;
    logic                        op_ready;
    logic [3:0]                  fpu_control;
    logic [DATA_W-1:0]           rs1_data;
    logic [DATA_W-1:0]           rs2_data;
    logic [NUM_UNITS-1:0]        unit_start;
    logic [DATA_W-1:0]           unit_a;
    logic [DATA_W-1:0]           unit_b;
    logic [3:0]                  unit_ctrl;
    logic [NUM_UNITS-1:0]        unit_done;
    logic [NUM_UNITS*DATA_W-1:0] unit_result;
    logic                        res_valid;
    logic                        res_ready;
    logic [DATA_W-1:0]           res_data;
    logic                        res_illegal;
    logic                        res_timeout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fpu_op_dispatch #(
        .DATA_W      (DATA_W),
        .NUM_UNITS   (NUM_UNITS),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .FPU_Control (fpu_control),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .unit_start  (unit_start),
        .unit_a      (unit_a),
        .unit_b      (unit_b),
        .unit_ctrl   (unit_ctrl),
        .unit_done   (unit_done),
        .unit_result (unit_result),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_illegal (res_illegal),
        .res_timeout (res_timeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: op code ranges per unit; -1 means no unit (illegal code).
    function automatic int model_unit(input int op);
        if (op <= 1)  return 0;
        if (op == 2)  return 1;
        if (op == 3)  return 2;
        if (op <= 6)  return 3;
        if (op <= 10) return 4;
        if (op <= 13) return 5;
        return -1;
    endfunction

    task automatic drive_results(input int u, input logic [31:0] r);
        for (int k = 0; k < NUM_UNITS; k++)
            unit_result[k*DATA_W +: DATA_W] = $urandom;
        unit_result[u*DATA_W +: DATA_W] = r;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_op_ready"},    32'(op_ready),    32'd1);
        check({tag, "_unit_start"},  32'(unit_start),  32'd0);
        check({tag, "_res_valid"},   32'(res_valid),   32'd0);
        check({tag, "_res_illegal"}, 32'(res_illegal), 32'd0);
        check({tag, "_res_timeout"}, 32'(res_timeout), 32'd0);
        check({tag, "_res_data"},    res_data,         32'd0);
        check({tag, "_unit_a"},      unit_a,           32'd0);
        check({tag, "_unit_b"},      unit_b,           32'd0);
        check({tag, "_unit_ctrl"},   32'(unit_ctrl),   32'd0);
    endtask

    // One full transaction: accept, optional wait of 'delay' cycles after ISSUE, then HOLD for 'hold' cycles.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int delay, input logic [31:0] r, input int hold,
                         input logic [NUM_UNITS-1:0] stuck);
        int u;
        logic [NUM_UNITS-1:0] noise;
        logic [31:0] exp_data;
        u = model_unit(int'(op));
        noise = stuck;
        if (u >= 0) noise[u] = 1'b0;
        @(negedge clk);
        op_valid = 1'b1; fpu_control = op; rs1_data = a; rs2_data = b; unit_done = noise;
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0; rs1_data = $urandom; rs2_data = $urandom;
        if (u < 0) begin
            check("ill_start",   32'(unit_start),  32'd0);
            check("ill_valid",   32'(res_valid),   32'd1);
            check("ill_flag",    32'(res_illegal), 32'd1);
            check("ill_data",    res_data,         32'd0);
            check("ill_ready",   32'(op_ready),    32'd0);
            exp_data = 32'd0;
        end else begin
            check("issue_start", 32'(unit_start), 32'(1 << u));
            check("issue_ready", 32'(op_ready),   32'd0);
            check("issue_a",     unit_a,          a);
            check("issue_b",     unit_b,          b);
            check("issue_ctrl",  32'(unit_ctrl),  32'(op));
            check("issue_valid", 32'(res_valid),  32'd0);
            for (int i = 0; i < delay; i++) begin
                @(posedge clk);
                @(negedge clk);
                check("wait_valid", 32'(res_valid),  32'd0);
                check("wait_start", 32'(unit_start), 32'd0);
                check("wait_ready", 32'(op_ready),   32'd0);
                check("wait_a",     unit_a,          a);
            end
            unit_done = noise;
            unit_done[u] = 1'b1;
            drive_results(u, r);
            @(posedge clk);
            @(negedge clk);
            unit_done = noise;
            drive_results(u, $urandom);
            check("done_valid",   32'(res_valid),   32'd1);
            check("done_data",    res_data,         r);
            check("done_illegal", 32'(res_illegal), 32'd0);
            check("done_start",   32'(unit_start),  32'd0);
            exp_data = r;
        end
        check("res_timeout_clear", 32'(res_timeout), 32'd0);
        op_valid = 1'b1; fpu_control = 4'($urandom_range(0, 13));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", 32'(res_valid),  32'd1);
            check("hold_data",  res_data,        exp_data);
            check("hold_ready", 32'(op_ready),   32'd0);
            check("hold_start", 32'(unit_start), 32'd0);
        end
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        check("rel_valid",   32'(res_valid),   32'd0);
        check("rel_ready",   32'(op_ready),    32'd1);
        check("rel_start",   32'(unit_start),  32'd0);
        check("rel_illegal", 32'(res_illegal), 32'd0);
        op_valid = 1'b0;
        unit_done = '0;
    endtask

    initial begin
        rst_n = 1'b0; op_valid = 1'b0; fpu_control = '0; rs1_data = '0; rs2_data = '0;
        unit_done = '0; unit_result = '0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_reset");

        do_op(4'd0,  32'h3F80_0000, 32'h4000_0000, 0,  32'h4040_0000, 2, '0);
        do_op(4'd3,  32'h4000_0000, 32'h4080_0000, 20, 32'h3F00_0000, 1, '0);
        do_op(4'd5,  32'h1234_5678, 32'h9ABC_DEF0, 6,  32'h0000_0001, 0, 6'b000010);
        do_op(4'd15, 32'hDEAD_BEEF, 32'hCAFE_F00D, 0,  32'h0,         5, '0);
        do_op(4'd14, 32'h0BAD_0BAD, 32'h1111_2222, 0,  32'h0,         0, '0);
        do_op(4'd13, 32'hBF80_0000, 32'h3F80_0000, 0,  32'h3F80_0000, 5, '0);

        for (int n = 0; n < 30; n++)
            do_op(4'($urandom_range(0, 15)), $urandom, $urandom, $urandom_range(0, 25),
                  $urandom, $urandom_range(0, 3), 6'($urandom));

        // Asynchronous reset while a divide is stalled in WAIT.
        @(negedge clk);
        op_valid = 1'b1; fpu_control = 4'd3; rs1_data = 32'h4110_0000; rs2_data = 32'h4040_0000;
        unit_done = '0;
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("midwait_ready", 32'(op_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("async_release");
        do_op(4'd2, 32'h4000_0000, 32'h4000_0000, 3, 32'h4080_0000, 1, '0);

`ifdef FPU_DISPATCH_TIMEOUT_EN
        @(negedge clk);
        op_valid = 1'b1; fpu_control = 4'd3; rs1_data = 32'h3F80_0000; rs2_data = 32'h0;
        unit_done = 6'b111011;
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        for (int i = 0; i < TIMEOUT_CYC; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("to_wait_valid", 32'(res_valid), 32'd0);
        end
        @(posedge clk);
        @(negedge clk);
        check("to_valid", 32'(res_valid),   32'd1);
        check("to_flag",  32'(res_timeout), 32'd1);
        check("to_data",  res_data,         32'd0);
        unit_done = '0;
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        check("to_release_flag",  32'(res_timeout), 32'd0);
        check("to_release_ready", 32'(op_ready),    32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
